// File: rtl/smi_frame_steer_x3.sv
// Whole-frame steering of one SMI input stream to three output ports (A/B/C) or a drop sink.
// The route field of each frame's first flit selects the destination for the entire frame.

module smi_frame_steer_x3_obuf #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic         in_valid,
    input  logic [W-1:0] in_flit,
    output logic         in_stop,
    output logic         out_valid,
    output logic [W-1:0] out_flit,
    input  logic         out_stop
);
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_flit_q, main_flit_d;
    logic [W-1:0] skid_flit_q, skid_flit_d;
    logic         push;
    logic         pop;

    // Stop toward the core is purely the skid occupancy, so it is a flop output.
    assign in_stop   = skid_valid_q;
    assign push      = in_valid & ~skid_valid_q;
    assign pop       = main_valid_q & ~out_stop;
    assign out_valid = main_valid_q;
    assign out_flit  = main_flit_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_flit_d  = main_flit_q;
        skid_flit_d  = skid_flit_q;
        if (skid_valid_q) begin
            if (pop) begin
                main_flit_d  = skid_flit_q;
                skid_valid_d = 1'b0;
            end
        end else if (push) begin
            if (main_valid_q && !pop) begin
                skid_valid_d = 1'b1;
                skid_flit_d  = in_flit;
            end else begin
                main_valid_d = 1'b1;
                main_flit_d  = in_flit;
            end
        end else if (pop) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_flit_q  <= '0;
            skid_flit_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_flit_q  <= main_flit_d;
            skid_flit_q  <= skid_flit_d;
        end
    end
endmodule

module smi_frame_steer_x3 #(
    parameter int FlitWidth = 2,
    parameter int RouteLsb  = 0
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   smiInReady,
    input  logic [7:0]             smiInEofc,
    input  logic [FlitWidth*8-1:0] smiInData,
    output logic                   smiInStop,
    output logic                   smiOutAReady,
    output logic [7:0]             smiOutAEofc,
    output logic [FlitWidth*8-1:0] smiOutAData,
    input  logic                   smiOutAStop,
    output logic                   smiOutBReady,
    output logic [7:0]             smiOutBEofc,
    output logic [FlitWidth*8-1:0] smiOutBData,
    input  logic                   smiOutBStop,
    output logic                   smiOutCReady,
    output logic [7:0]             smiOutCEofc,
    output logic [FlitWidth*8-1:0] smiOutCData,
    input  logic                   smiOutCStop,
    output logic [7:0]             dropCount
);
    localparam int DW = FlitWidth * 8;
    localparam int W  = DW + 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD_A,
        ST_FWD_B,
        ST_FWD_C,
        ST_DROP
    } state_e;

    state_e          state_q, state_d;
    logic            in_ready_q;
    logic [7:0]      in_eofc_q;
    logic [DW-1:0]   in_data_q;
    logic            in_last_q;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic            consume;
    logic            load;
    logic [1:0]      sel;
    logic            sel_stop;
    logic [2:0]      core_valid;
    logic [2:0]      core_stop;
    logic [2:0]      ob_valid;
    logic [2:0]      ob_stop;
    logic [W-1:0]    core_flit;
    logic [W-1:0]    ob_flit [3];

    assign load      = ~in_ready_q | consume;
    assign smiInStop = in_ready_q & ~consume;
    assign core_flit = {in_eofc_q, in_data_q};
    assign ob_stop   = {smiOutCStop, smiOutBStop, smiOutAStop};
    assign dropCount = drop_cnt_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            in_ready_q <= 1'b0;
            in_eofc_q  <= '0;
            in_data_q  <= '0;
            in_last_q  <= 1'b0;
        end else if (load) begin
            in_ready_q <= smiInReady;
            in_eofc_q  <= smiInEofc;
            in_data_q  <= smiInData;
            in_last_q  <= |smiInEofc;
        end
    end

    // sel: 0..2 = port A..C, 3 = drop. In Idle the header is decoded and forwarded at once.
    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        consume    = 1'b0;
        core_valid = 3'b000;
        sel        = 2'd0;
        sel_stop   = 1'b0;
        case (state_q)
            ST_IDLE:  sel = in_data_q[RouteLsb+1 -: 2];
            ST_FWD_A: sel = 2'd0;
            ST_FWD_B: sel = 2'd1;
            ST_FWD_C: sel = 2'd2;
            default:  sel = 2'd3;
        endcase
        case (sel)
            2'd0:    sel_stop = core_stop[0];
            2'd1:    sel_stop = core_stop[1];
            2'd2:    sel_stop = core_stop[2];
            default: sel_stop = 1'b0;
        endcase
        if (in_ready_q) begin
            if (sel != 2'd3) begin
                core_valid = 3'b001 << sel;
            end
            consume = ~sel_stop;
            if (consume) begin
                if (in_last_q) begin
                    state_d = ST_IDLE;
                    if (sel == 2'd3 && drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end else begin
                    case (sel)
                        2'd0:    state_d = ST_FWD_A;
                        2'd1:    state_d = ST_FWD_B;
                        2'd2:    state_d = ST_FWD_C;
                        default: state_d = ST_DROP;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= ST_IDLE;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_port
        smi_frame_steer_x3_obuf #(.W(W)) u_obuf (
            .clk       (clk),
            .arstn     (arstn),
            .in_valid  (core_valid[gi]),
            .in_flit   (core_flit),
            .in_stop   (core_stop[gi]),
            .out_valid (ob_valid[gi]),
            .out_flit  (ob_flit[gi]),
            .out_stop  (ob_stop[gi])
        );
    end

    assign smiOutAReady               = ob_valid[0];
    assign {smiOutAEofc, smiOutAData} = ob_flit[0];
    assign smiOutBReady               = ob_valid[1];
    assign {smiOutBEofc, smiOutBData} = ob_flit[1];
    assign smiOutCReady               = ob_valid[2];
    assign {smiOutCEofc, smiOutCData} = ob_flit[2];
endmodule

// File: tb/tb_smi_frame_steer_x3.sv
// Scoreboard bench for smi_frame_steer_x3: directed frames push expected flits per port,
// a negedge monitor pops and compares every flit the DUT hands to a consumer.

module tb_smi_frame_steer_x3;
    logic        clk = 1'b0;
    logic        arstn;
    logic        smiInReady;
    logic [7:0]  smiInEofc;
    logic [15:0] smiInData;
    logic        smiInStop;
    logic        smiOutAReady, smiOutBReady, smiOutCReady;
    logic [7:0]  smiOutAEofc, smiOutBEofc, smiOutCEofc;
    logic [15:0] smiOutAData, smiOutBData, smiOutCData;
    logic        smiOutAStop, smiOutBStop, smiOutCStop;
    logic [7:0]  dropCount;

    always #5 clk = ~clk;

    smi_frame_steer_x3 #(.FlitWidth(2), .RouteLsb(0)) dut (
        .clk          (clk),
        .arstn        (arstn),
        .smiInReady   (smiInReady),
        .smiInEofc    (smiInEofc),
        .smiInData    (smiInData),
        .smiInStop    (smiInStop),
        .smiOutAReady (smiOutAReady),
        .smiOutAEofc  (smiOutAEofc),
        .smiOutAData  (smiOutAData),
        .smiOutAStop  (smiOutAStop),
        .smiOutBReady (smiOutBReady),
        .smiOutBEofc  (smiOutBEofc),
        .smiOutBData  (smiOutBData),
        .smiOutBStop  (smiOutBStop),
        .smiOutCReady (smiOutCReady),
        .smiOutCEofc  (smiOutCEofc),
        .smiOutCData  (smiOutCData),
        .smiOutCStop  (smiOutCStop),
        .dropCount    (dropCount)
    );

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];
    logic [23:0] exp_c[$];
    int exp_drop = 0;
    int cyc = 0;
    int in_xfers = 0;
    int pres_cyc = 0;
    int hdr_cyc = 0;
    int first_cyc[3];
    int last_cyc[3];
    bit first_seen[3];
    int pop_cnt[3];
    bit send_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic pop_port(input int p, input logic [23:0] got);
        logic [23:0] e;
        int sz;
        if (!first_seen[p]) begin
            first_seen[p] = 1'b1;
            first_cyc[p]  = cyc;
        end
        last_cyc[p] = cyc;
        pop_cnt[p]++;
        sz = (p == 0) ? exp_a.size() : (p == 1) ? exp_b.size() : exp_c.size();
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL out_%0d_unexpected: got %h expected none", p, got);
        end else begin
            case (p)
                0:       e = exp_a.pop_front();
                1:       e = exp_b.pop_front();
                default: e = exp_c.pop_front();
            endcase
            chk($sformatf("out_%0d_flit", p), {8'h0, got}, {8'h0, e});
        end
    endtask

    always @(negedge clk) begin
        if (arstn) begin
            if (smiOutAReady && !smiOutAStop) pop_port(0, {smiOutAEofc, smiOutAData});
            if (smiOutBReady && !smiOutBStop) pop_port(1, {smiOutBEofc, smiOutBData});
            if (smiOutCReady && !smiOutCStop) pop_port(2, {smiOutCEofc, smiOutCData});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_marks();
        for (int i = 0; i < 3; i++) first_seen[i] = 1'b0;
    endtask

    task automatic send_flit(input logic [7:0] e, input logic [15:0] d, output int stalls);
        int n;
        bit st;
        n = 0;
        smiInReady = 1'b1;
        smiInEofc  = e;
        smiInData  = d;
        do begin
            @(negedge clk);
            st = smiInStop;
            if (!st) pres_cyc = cyc;
            @(posedge clk);
            #1;
            if (st) n++;
        end while (st && n < 200);
        if (st) begin
            checks++;
            errors++;
            $display("FAIL in_stall_timeout: got stalled expected accepted");
        end else begin
            in_xfers++;
        end
        stalls     = n;
        smiInReady = 1'b0;
        smiInEofc  = 8'h0;
        smiInData  = 16'h0;
    endtask

    // Flit i carries base+i; route comes from the header's low bits only.
    task automatic send_frame(input int nfl, input logic [15:0] base, input logic [7:0] leof,
                              output int stalls_total);
        logic [1:0] route;
        logic [15:0] d;
        logic [7:0] e;
        int s;
        route = base[1:0];
        stalls_total = 0;
        for (int i = 0; i < nfl; i++) begin
            d = base + 16'(i);
            e = (i == nfl - 1) ? leof : 8'h00;
            case (route)
                2'd0: exp_a.push_back({e, d});
                2'd1: exp_b.push_back({e, d});
                2'd2: exp_c.push_back({e, d});
                default: ;
            endcase
            send_flit(e, d, s);
            stalls_total += s;
            if (i == 0) hdr_cyc = pres_cyc;
        end
        if (route == 2'd3 && exp_drop < 255) exp_drop++;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_a.size() + exp_b.size() + exp_c.size()) != 0 && n < 300) begin
            tick(1);
            n++;
        end
        tick(2);
        chk(name, 32'(exp_a.size() + exp_b.size() + exp_c.size()), 32'd0);
    endtask

    initial begin
        int st;
        int x0;
        int n;
        int pb;
        arstn = 1'b0;
        smiInReady = 1'b0;
        smiInEofc = 8'h0;
        smiInData = 16'h0;
        smiOutAStop = 1'b0;
        smiOutBStop = 1'b0;
        smiOutCStop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            first_seen[i] = 1'b0;
            pop_cnt[i] = 0;
        end
        tick(2);
        chk("rst_ready_abc", {29'h0, smiOutAReady, smiOutBReady, smiOutCReady}, 32'h0);
        chk("rst_in_stop", {31'h0, smiInStop}, 32'h0);
        chk("rst_drop_count", {24'h0, dropCount}, 32'h0);
        arstn = 1'b1;
        tick(2);

        // 1: 4-flit frame to B; header presented in cycle 0 appears on B in cycle 2.
        clear_marks();
        send_frame(4, 16'h1101, 8'h02, st);
        wait_drain("t1_drain");
        chk("t1_latency", 32'(first_cyc[1] - hdr_cyc), 32'd2);
        chk("t1_b_contiguous", 32'(last_cyc[1] - first_cyc[1]), 32'd3);
        chk("t1_no_a_c", 32'(pop_cnt[0] + pop_cnt[2]), 32'd0);

        // 2: single-flit frames A, C, A back-to-back.
        clear_marks();
        x0 = 0;
        send_frame(1, 16'h2000, 8'h01, st); x0 += st;
        send_frame(1, 16'h2002, 8'h01, st); x0 += st;
        send_frame(1, 16'h2004, 8'h01, st); x0 += st;
        wait_drain("t2_drain");
        chk("t2_input_stalls", 32'(x0), 32'd0);
        chk("t2_c_after_a", 32'(first_cyc[2] - first_cyc[0]), 32'd1);
        chk("t2_a_span", 32'(last_cyc[0] - first_cyc[0]), 32'd2);

        // 3: A stalled: two flits buffered plus one in the input register, then stop.
        smiOutAStop = 1'b1;
        x0 = in_xfers;
        send_done = 1'b0;
        fork
            begin
                int s3;
                send_frame(6, 16'h4000, 8'h04, s3);
                send_done = 1'b1;
            end
        join_none
        tick(10);
        chk("t3_accepted_while_stalled", 32'(in_xfers - x0), 32'd3);
        chk("t3_in_stop", {31'h0, smiInStop}, 32'h1);
        chk("t3_a_ready_held", {31'h0, smiOutAReady}, 32'h1);
        smiOutAStop = 1'b0;
        n = 0;
        while (!send_done && n < 100) begin
            tick(1);
            n++;
        end
        chk("t3_send_done", {31'h0, send_done}, 32'h1);
        wait_drain("t3_drain");

        // 4: three dropped frames of differing lengths, then a frame to C.
        pb = pop_cnt[0] + pop_cnt[1];
        send_frame(2, 16'h3003, 8'h01, st);
        send_frame(1, 16'h3103, 8'h01, st);
        send_frame(3, 16'h3203, 8'h01, st);
        send_frame(2, 16'h3302, 8'h03, st);
        wait_drain("t4_drain");
        chk("t4_drop_count", {24'h0, dropCount}, 32'(exp_drop));
        chk("t4_no_a_b", 32'(pop_cnt[0] + pop_cnt[1] - pb), 32'd0);

        // 5: reset with two flits of a B frame parked in B's buffer.
        smiOutBStop = 1'b1;
        send_flit(8'h00, 16'h5001, st);
        send_flit(8'h00, 16'h5002, st);
        tick(3);
        chk("t5_b_ready_pre_reset", {31'h0, smiOutBReady}, 32'h1);
        #2;
        arstn = 1'b0;
        #1;
        chk("t5_ready_abc_in_reset", {29'h0, smiOutAReady, smiOutBReady, smiOutCReady}, 32'h0);
        chk("t5_in_stop_in_reset", {31'h0, smiInStop}, 32'h0);
        chk("t5_drop_in_reset", {24'h0, dropCount}, 32'h0);
        exp_drop = 0;
        tick(1);
        arstn = 1'b1;
        smiOutBStop = 1'b0;
        pb = pop_cnt[1];
        tick(5);
        send_frame(3, 16'h6000, 8'h05, st);
        wait_drain("t5_drain");
        chk("t5_no_b_tail", 32'(pop_cnt[1] - pb), 32'd0);

        // 6: drop counter saturates.
        for (int i = 0; i < 260; i++) send_frame(1, 16'h7003, 8'h01, st);
        tick(3);
        chk("t6_drop_saturated", {24'h0, dropCount}, 32'(exp_drop));
        chk("t6_model_255", 32'(exp_drop), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
